// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two read ports with busy flags, one write port,
// the scoreboard set port and the busy count.
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] read1;
   logic [ADDR_W-1:0] read2;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic              busy1;
   logic              busy2;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic              RegWrite;
   logic              set_busy;
   logic [ADDR_W-1:0] busy_reg;
   logic [ADDR_W:0]   busy_cnt;

   // No valid/ready handshake on this bus: RegWrite and set_busy are
   // single-cycle strobes sampled at every rising edge, and they are always
   // accepted. Reads, data and busy flags are combinational. busy_cnt is
   // registered.
   modport master (
      output read1, read2, write_reg, write_data, RegWrite, set_busy, busy_reg,
      input  data1, data2, busy1, busy2, busy_cnt
   );

   modport slave (
      input  read1, read2, write_reg, write_data, RegWrite, set_busy, busy_reg,
      output data1, data2, busy1, busy2, busy_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_sb_if.slave  bus
);
   localparam int              DEPTH     = 1 << ADDR_W;
   localparam bit              HAS_ZERO  = (ZERO_REG != 0);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
   localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_next;

   logic              write_en;
   logic              set_en;
   logic              cnt_inc;
   logic              cnt_dec;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   // Register 0 is hard-wired when ZERO_REG is on: never written, never set busy.
   assign write_en = bus.RegWrite && !(HAS_ZERO && (bus.write_reg == ZERO_ADDR));
   assign set_en   = bus.set_busy && !(HAS_ZERO && (bus.busy_reg == ZERO_ADDR));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write_en) begin
         mem[bus.write_reg] <= bus.write_data;
      end
   end

   // Clear first, then set, so a new producer supersedes the completing one.
   always_comb begin
      busy_next = busy;
      if (bus.RegWrite) begin
         busy_next[bus.write_reg] = 1'b0;
      end
      if (set_en) begin
         busy_next[bus.busy_reg] = 1'b1;
      end
   end

   // Count only effective transitions so cnt stays equal to popcount(busy).
   assign cnt_inc = set_en && !busy[bus.busy_reg];
   assign cnt_dec = bus.RegWrite && busy[bus.write_reg] &&
                    !(set_en && (bus.busy_reg == bus.write_reg));

   always_comb begin
      cnt_next = cnt;
      if (cnt_inc && !cnt_dec) begin
         cnt_next = cnt + CNT_ONE;
      end else if (cnt_dec && !cnt_inc) begin
         cnt_next = cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         busy <= busy_next;
         cnt  <= cnt_next;
      end
   end

   always_comb begin
      rd1 = mem[bus.read1];
      rd2 = mem[bus.read2];
      if (HAS_ZERO && (bus.read1 == ZERO_ADDR)) begin
         rd1 = '0;
      end
      if (HAS_ZERO && (bus.read2 == ZERO_ADDR)) begin
         rd2 = '0;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic hit1;
   logic hit2;

   assign hit1 = write_en && (bus.write_reg == bus.read1);
   assign hit2 = write_en && (bus.write_reg == bus.read2);

   always_comb begin
      bus.data1 = hit1 ? bus.write_data : rd1;
      bus.data2 = hit2 ? bus.write_data : rd2;
      bus.busy1 = hit1 ? (set_en && (bus.busy_reg == bus.read1)) : busy[bus.read1];
      bus.busy2 = hit2 ? (set_en && (bus.busy_reg == bus.read2)) : busy[bus.read2];
   end
`else
   always_comb begin
      bus.data1 = rd1;
      bus.data2 = rd2;
      bus.busy1 = busy[bus.read1];
      bus.busy2 = busy[bus.read2];
   end
`endif

   assign bus.busy_cnt = cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a 32x32 zero-reg instance and a 4-entry
// instance without zero reg for scoreboard saturation.
module tb_regfile_sb;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) m_if ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(2)) s_if ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(2), .ZERO_REG(0)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_if.read1 = '0; m_if.read2 = '0; m_if.write_reg = '0; m_if.write_data = '0;
    m_if.RegWrite = 1'b0; m_if.set_busy = 1'b0; m_if.busy_reg = '0;
    s_if.read1 = '0; s_if.read2 = '0; s_if.write_reg = '0; s_if.write_data = '0;
    s_if.RegWrite = 1'b0; s_if.set_busy = 1'b0; s_if.busy_reg = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1 rst = 1'b0;
    #1;
    m_if.read1 = 5'd1;
    #1;
    checks++; if (m_if.data1 !== 32'h0) begin errors++; $display("FAIL reset_data1 got %0h want 0", m_if.data1); end
    checks++; if (m_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", m_if.busy_cnt); end
    rst = 1'b1;
    // r1 <= all ones, r2 busy, then reset mid-cycle
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd1; m_if.write_data = 32'hFFFF_FFFF;
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd2; m_if.read2 = 5'd2;
    tick();
    m_if.RegWrite = 1'b0; m_if.set_busy = 1'b0;
    #1;
    checks++; if (m_if.data1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pre_reset_data1 got %0h want ffffffff", m_if.data1); end
    checks++; if (m_if.busy_cnt !== 6'd1) begin errors++; $display("FAIL pre_reset_cnt got %0d want 1", m_if.busy_cnt); end
    #1 rst = 1'b0;
    #1;
    checks++; if (m_if.data1 !== 32'h0) begin errors++; $display("FAIL async_reset_data1 got %0h want 0", m_if.data1); end
    checks++; if (m_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL async_reset_cnt got %0d want 0", m_if.busy_cnt); end
    checks++; if (m_if.busy2 !== 1'b0) begin errors++; $display("FAIL async_reset_busy2 got %0b want 0", m_if.busy2); end
    // edge while in reset is ignored
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd1; m_if.write_data = 32'd5;
    tick();
    m_if.RegWrite = 1'b0;
    #1;
    checks++; if (m_if.data1 !== 32'h0) begin errors++; $display("FAIL reset_holds_data1 got %0h want 0", m_if.data1); end
    // first edge after release honours the write
    m_if.RegWrite = 1'b1;
    #1 rst = 1'b1;
    tick();
    m_if.RegWrite = 1'b0;
    #1;
    checks++; if (m_if.data1 !== 32'd5) begin errors++; $display("FAIL post_release_write got %0h want 5", m_if.data1); end
  endtask

  task automatic test_write_read();
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd1; m_if.write_data = 32'd1;
    m_if.read1 = 5'd1; m_if.read2 = 5'd1;
    tick();
    m_if.RegWrite = 1'b0; m_if.write_data = 32'd7;
    #1;
    checks++; if (m_if.data1 !== 32'd1) begin errors++; $display("FAIL write_read_data1 got %0h want 1", m_if.data1); end
    checks++; if (m_if.data2 !== 32'd1) begin errors++; $display("FAIL write_read_data2 got %0h want 1", m_if.data2); end
    tick();
    checks++; if (m_if.data1 !== 32'd1) begin errors++; $display("FAIL no_enable_data1 got %0h want 1", m_if.data1); end
  endtask

  task automatic test_zero_reg();
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd0; m_if.write_data = 32'h1234;
    m_if.read1 = 5'd0;
    #1;
    checks++; if (m_if.data1 !== 32'h0) begin errors++; $display("FAIL zero_same_cycle got %0h want 0", m_if.data1); end
    tick();
    m_if.RegWrite = 1'b0;
    #1;
    checks++; if (m_if.data1 !== 32'h0) begin errors++; $display("FAIL zero_after_write got %0h want 0", m_if.data1); end
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd0;
    tick();
    m_if.set_busy = 1'b0;
    #1;
    checks++; if (m_if.busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy1 got %0b want 0", m_if.busy1); end
    checks++; if (m_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt got %0d want 0", m_if.busy_cnt); end
  endtask

  task automatic test_scoreboard();
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd3;
    tick();
    m_if.busy_reg = 5'd5;
    tick();
    m_if.set_busy = 1'b0; m_if.read1 = 5'd3; m_if.read2 = 5'd5;
    #1;
    checks++; if (m_if.busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_cnt_two got %0d want 2", m_if.busy_cnt); end
    checks++; if (m_if.busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_r3 got %0b want 1", m_if.busy1); end
    checks++; if (m_if.busy2 !== 1'b1) begin errors++; $display("FAIL sb_busy_r5 got %0b want 1", m_if.busy2); end
    // set r7 while r3 completes: net zero
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd7;
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd3; m_if.write_data = 32'd33;
    tick();
    m_if.set_busy = 1'b0; m_if.RegWrite = 1'b0; m_if.read2 = 5'd7;
    #1;
    checks++; if (m_if.busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_net_zero_cnt got %0d want 2", m_if.busy_cnt); end
    checks++; if (m_if.busy1 !== 1'b0) begin errors++; $display("FAIL sb_r3_cleared got %0b want 0", m_if.busy1); end
    checks++; if (m_if.data1 !== 32'd33) begin errors++; $display("FAIL sb_r3_data got %0h want 21", m_if.data1); end
    checks++; if (m_if.busy2 !== 1'b1) begin errors++; $display("FAIL sb_r7_set got %0b want 1", m_if.busy2); end
    // set and clear r5 together: set wins, data written
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd5;
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd5; m_if.write_data = 32'd55;
    tick();
    m_if.set_busy = 1'b0; m_if.RegWrite = 1'b0; m_if.read1 = 5'd5;
    #1;
    checks++; if (m_if.busy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %0b want 1", m_if.busy1); end
    checks++; if (m_if.data1 !== 32'd55) begin errors++; $display("FAIL sb_set_wins_data got %0h want 37", m_if.data1); end
    checks++; if (m_if.busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_set_wins_cnt got %0d want 2", m_if.busy_cnt); end
    // clear r7, then clear non-busy r3, then re-set busy r5
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd7; m_if.write_data = 32'd77;
    tick();
    m_if.RegWrite = 1'b0;
    #1;
    checks++; if (m_if.busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_clear_cnt got %0d want 1", m_if.busy_cnt); end
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd3;
    tick();
    m_if.RegWrite = 1'b0; m_if.set_busy = 1'b1; m_if.busy_reg = 5'd5;
    tick();
    m_if.set_busy = 1'b0;
    #1;
    checks++; if (m_if.busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_redundant_cnt got %0d want 1", m_if.busy_cnt); end
    // set r6 while r5 completes
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd6;
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd5; m_if.write_data = 32'd56;
    tick();
    m_if.set_busy = 1'b0; m_if.RegWrite = 1'b0; m_if.read2 = 5'd6;
    #1;
    checks++; if (m_if.busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_swap_cnt got %0d want 1", m_if.busy_cnt); end
    checks++; if (m_if.busy1 !== 1'b0) begin errors++; $display("FAIL sb_swap_r5 got %0b want 0", m_if.busy1); end
    checks++; if (m_if.busy2 !== 1'b1) begin errors++; $display("FAIL sb_swap_r6 got %0b want 1", m_if.busy2); end
  endtask

  task automatic test_bypass();
    m_if.RegWrite = 1'b1; m_if.write_reg = 5'd4; m_if.write_data = 32'd10;
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd4;
    tick();
    m_if.set_busy = 1'b0; m_if.write_data = 32'd20;
    m_if.read1 = 5'd4; m_if.read2 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (m_if.data1 !== 32'd20) begin errors++; $display("FAIL byp_data1 got %0d want 20", m_if.data1); end
    checks++; if (m_if.data2 !== 32'd20) begin errors++; $display("FAIL byp_data2 got %0d want 20", m_if.data2); end
    checks++; if (m_if.busy1 !== 1'b0) begin errors++; $display("FAIL byp_busy1 got %0b want 0", m_if.busy1); end
    checks++; if (m_if.busy2 !== 1'b0) begin errors++; $display("FAIL byp_busy2 got %0b want 0", m_if.busy2); end
`else
    checks++; if (m_if.data1 !== 32'd10) begin errors++; $display("FAIL nobyp_data1 got %0d want 10", m_if.data1); end
    checks++; if (m_if.data2 !== 32'd10) begin errors++; $display("FAIL nobyp_data2 got %0d want 10", m_if.data2); end
    checks++; if (m_if.busy1 !== 1'b1) begin errors++; $display("FAIL nobyp_busy1 got %0b want 1", m_if.busy1); end
    checks++; if (m_if.busy2 !== 1'b1) begin errors++; $display("FAIL nobyp_busy2 got %0b want 1", m_if.busy2); end
`endif
    tick();
    m_if.RegWrite = 1'b0;
    #1;
    checks++; if (m_if.data1 !== 32'd20) begin errors++; $display("FAIL after_edge_data1 got %0d want 20", m_if.data1); end
    checks++; if (m_if.data2 !== 32'd20) begin errors++; $display("FAIL after_edge_data2 got %0d want 20", m_if.data2); end
    checks++; if (m_if.busy1 !== 1'b0) begin errors++; $display("FAIL after_edge_busy1 got %0b want 0", m_if.busy1); end
    checks++; if (m_if.busy_cnt !== 6'd1) begin errors++; $display("FAIL after_edge_cnt got %0d want 1", m_if.busy_cnt); end
    // write plus set on the read register in the same cycle
    m_if.RegWrite = 1'b1; m_if.write_data = 32'd30;
    m_if.set_busy = 1'b1; m_if.busy_reg = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (m_if.busy1 !== 1'b1) begin errors++; $display("FAIL byp_set_busy1 got %0b want 1", m_if.busy1); end
    checks++; if (m_if.data1 !== 32'd30) begin errors++; $display("FAIL byp_set_data1 got %0d want 30", m_if.data1); end
`else
    checks++; if (m_if.busy1 !== 1'b0) begin errors++; $display("FAIL nobyp_set_busy1 got %0b want 0", m_if.busy1); end
    checks++; if (m_if.data1 !== 32'd20) begin errors++; $display("FAIL nobyp_set_data1 got %0d want 20", m_if.data1); end
`endif
    tick();
    m_if.RegWrite = 1'b0; m_if.set_busy = 1'b0;
    #1;
    checks++; if (m_if.busy1 !== 1'b1) begin errors++; $display("FAIL set_after_edge_busy1 got %0b want 1", m_if.busy1); end
    checks++; if (m_if.data1 !== 32'd30) begin errors++; $display("FAIL set_after_edge_data1 got %0d want 30", m_if.data1); end
    checks++; if (m_if.busy_cnt !== 6'd2) begin errors++; $display("FAIL set_after_edge_cnt got %0d want 2", m_if.busy_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      s_if.set_busy = 1'b1; s_if.busy_reg = i[1:0];
      tick();
    end
    s_if.set_busy = 1'b0;
    #1;
    checks++; if (s_if.busy_cnt !== 3'd4) begin errors++; $display("FAIL sat_full_cnt got %0d want 4", s_if.busy_cnt); end
    s_if.set_busy = 1'b1; s_if.busy_reg = 2'd2;
    tick();
    s_if.set_busy = 1'b0;
    #1;
    checks++; if (s_if.busy_cnt !== 3'd4) begin errors++; $display("FAIL sat_reset_cnt got %0d want 4", s_if.busy_cnt); end
    // r0 is ordinary here
    s_if.RegWrite = 1'b1; s_if.write_reg = 2'd0; s_if.write_data = 32'd9;
    tick();
    s_if.RegWrite = 1'b0; s_if.read1 = 2'd0; s_if.read2 = 2'd3;
    #1;
    checks++; if (s_if.data1 !== 32'd9) begin errors++; $display("FAIL sat_r0_data got %0d want 9", s_if.data1); end
    checks++; if (s_if.busy1 !== 1'b0) begin errors++; $display("FAIL sat_r0_busy got %0b want 0", s_if.busy1); end
    checks++; if (s_if.busy2 !== 1'b1) begin errors++; $display("FAIL sat_r3_busy got %0b want 1", s_if.busy2); end
    checks++; if (s_if.busy_cnt !== 3'd3) begin errors++; $display("FAIL sat_dec_cnt got %0d want 3", s_if.busy_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
